// File: rtl/clk_count_min_sec_if.sv
// Control and time-value bundle of the minute/second stage.
// master drives the controls and buttons; slave is the counter itself.
interface clk_count_min_sec_if;
    logic       run_en;
    logic       set_mode;
    logic       btn_min;
    logic       btn_hr;
    logic [7:0] sec;
    logic [7:0] min;
    logic       tick_1hz;
    logic       count_up_hr;

    modport master (
        output run_en, set_mode, btn_min, btn_hr,
        input  sec, min, tick_1hz, count_up_hr
    );

    modport slave (
        input  run_en, set_mode, btn_min, btn_hr,
        output sec, min, tick_1hz, count_up_hr
    );
endinterface

// File: rtl/clk_count_min_sec.sv
// 1 Hz timebase plus seconds/minutes counters of the digital clock, with a
// set-time mode where button edges step minutes and request hour increments.
module clk_count_min_sec #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRE_W    = 26
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               rst_counters,
    clk_count_min_sec_if.slave bus
);

    localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic             tick_q, tick_d;
    logic             hr_q, hr_d;
    logic             btn_min_q, btn_hr_q;

    logic edge_min, edge_hr;
    logic sec_last, min_last, pre_last;

    always_comb begin
        edge_min = bus.btn_min & ~btn_min_q;
        edge_hr  = bus.btn_hr & ~btn_hr_q;
        sec_last = (sec_q == 6'd59);
        min_last = (min_q == 6'd59);
        pre_last = (pre_q == PreMax);

        pre_d  = pre_q;
        sec_d  = sec_q;
        min_d  = min_q;
        tick_d = 1'b0;
        hr_d   = 1'b0;

        if (rst_counters) begin
            pre_d = '0;
            sec_d = '0;
            min_d = '0;
        end else if (bus.set_mode) begin
            // Set mode parks the timebase so leaving it starts a full second.
            pre_d = '0;
            sec_d = '0;
            hr_d  = edge_hr;
            if (edge_min) begin
                min_d = min_last ? 6'd0 : min_q + 6'd1;
            end
        end else if (bus.run_en) begin
            if (pre_last) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (sec_last) begin
                    sec_d = 6'd0;
                    if (min_last) begin
                        min_d = 6'd0;
                        hr_d  = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            pre_q     <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            tick_q    <= 1'b0;
            hr_q      <= 1'b0;
            btn_min_q <= 1'b0;
            btn_hr_q  <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            tick_q    <= tick_d;
            hr_q      <= hr_d;
            // Edge registers track the buttons even through rst_counters.
            btn_min_q <= bus.btn_min;
            btn_hr_q  <= bus.btn_hr;
        end
    end

    assign bus.sec         = {2'b00, sec_q};
    assign bus.min         = {2'b00, min_q};
    assign bus.tick_1hz    = tick_q;
    assign bus.count_up_hr = hr_q;

    a_time_range: assert property (@(posedge CLK) disable iff (rst)
        (sec_q < 6'd60) && (min_q < 6'd60));

endmodule

// File: tb/tb_clk_count_min_sec.sv
// Randomised and directed bench for clk_count_min_sec against a seconds-of-hour
// reference model.
module tb_clk_count_min_sec;

    localparam int unsigned TickDiv = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst_counters;

    clk_count_min_sec_if bus ();

    clk_count_min_sec #(
        .TICK_DIV(TickDiv),
        .PRE_W   (3)
    ) u_dut (
        .CLK         (clk),
        .rst         (rst),
        .rst_counters(rst_counters),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: cycles into the current second and seconds into the hour.
    int m_cyc = 0;
    int m_t   = 0;
    int m_tick = 0;
    int m_hr  = 0;
    int m_pbm = 0;
    int m_pbh = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int em;
        int eh;
        if (rst) begin
            m_cyc = 0; m_t = 0; m_tick = 0; m_hr = 0; m_pbm = 0; m_pbh = 0;
            return;
        end
        em = (bus.btn_min && !m_pbm) ? 1 : 0;
        eh = (bus.btn_hr && !m_pbh) ? 1 : 0;
        m_pbm = int'(bus.btn_min);
        m_pbh = int'(bus.btn_hr);
        m_tick = 0;
        m_hr = 0;
        if (rst_counters) begin
            m_cyc = 0;
            m_t = 0;
        end else if (bus.set_mode) begin
            m_cyc = 0;
            m_t = (em != 0) ? ((m_t / 60 + 1) % 60) * 60 : (m_t / 60) * 60;
            m_hr = eh;
        end else if (bus.run_en) begin
            m_cyc++;
            if (m_cyc == TickDiv) begin
                m_cyc = 0;
                m_tick = 1;
                m_t++;
                if (m_t == 3600) begin
                    m_t = 0;
                    m_hr = 1;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_eq("sec", int'(bus.sec), m_t % 60);
            check_eq("min", int'(bus.min), m_t / 60);
            check_eq("tick_1hz", int'(bus.tick_1hz), m_tick);
            check_eq("count_up_hr", int'(bus.count_up_hr), m_hr);
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_min = 1'b1;
            cyc(1);
            bus.btn_min = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_counters = 1'b0;
        bus.run_en = 1'b0;
        bus.set_mode = 1'b0;
        bus.btn_min = 1'b0;
        bus.btn_hr = 1'b0;
        cyc(2);
        check_eq("reset_sec", int'(bus.sec), 0);
        check_eq("reset_min", int'(bus.min), 0);

        // First ticks land on cycles 4, 8, 12 after reset.
        rst = 1'b0;
        bus.run_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            check_eq("first_ticks", int'(bus.tick_1hz), (i % 4 == 0) ? 1 : 0);
            check_eq("first_sec", int'(bus.sec), i / 4);
        end

        // Pause with the prescaler at 2; next tick 2 cycles after resuming.
        cyc(2);
        bus.run_en = 1'b0;
        cyc(10);
        check_eq("pause_sec", int'(bus.sec), 3);
        bus.run_en = 1'b1;
        cyc(1);
        check_eq("resume_tick0", int'(bus.tick_1hz), 0);
        cyc(1);
        check_eq("resume_tick1", int'(bus.tick_1hz), 1);
        check_eq("resume_sec", int'(bus.sec), 4);

        // Set mode: held button is one edge, then two pulses wrap 59 -> 0 -> 1.
        bus.set_mode = 1'b1;
        cyc(1);
        check_eq("set_sec0", int'(bus.sec), 0);
        pulse_min(58);
        check_eq("set_min58", int'(bus.min), 58);
        bus.btn_min = 1'b1;
        cyc(5);
        check_eq("held_min", int'(bus.min), 59);
        bus.btn_min = 1'b0;
        cyc(1);
        bus.btn_min = 1'b1;
        cyc(1);
        check_eq("wrap_min0", int'(bus.min), 0);
        check_eq("wrap_no_hr", int'(bus.count_up_hr), 0);
        bus.btn_min = 1'b0;
        cyc(1);
        bus.btn_min = 1'b1;
        cyc(1);
        check_eq("wrap_min1", int'(bus.min), 1);
        bus.btn_min = 1'b0;
        cyc(1);

        // Both buttons rise together: both act on the same edge.
        bus.btn_min = 1'b1;
        bus.btn_hr = 1'b1;
        cyc(1);
        check_eq("both_hr", int'(bus.count_up_hr), 1);
        check_eq("both_min", int'(bus.min), 2);
        cyc(1);
        check_eq("both_hr_once", int'(bus.count_up_hr), 0);
        bus.btn_min = 1'b0;
        bus.btn_hr = 1'b0;
        cyc(1);

        // 59:59 -> 00:00 with an hour carry.
        pulse_min(57);
        bus.set_mode = 1'b0;
        cyc(59 * 4);
        check_eq("pre_sec59", int'(bus.sec), 59);
        check_eq("pre_min59", int'(bus.min), 59);
        cyc(4);
        check_eq("carry_sec", int'(bus.sec), 0);
        check_eq("carry_min", int'(bus.min), 0);
        check_eq("carry_hr", int'(bus.count_up_hr), 1);
        cyc(1);
        check_eq("carry_hr_once", int'(bus.count_up_hr), 0);

        // rst_counters at 12:30 while running.
        bus.set_mode = 1'b1;
        cyc(1);
        pulse_min(12);
        bus.set_mode = 1'b0;
        cyc(120);
        check_eq("clr_pre_sec", int'(bus.sec), 30);
        check_eq("clr_pre_min", int'(bus.min), 12);
        rst_counters = 1'b1;
        cyc(1);
        rst_counters = 1'b0;
        check_eq("clr_sec", int'(bus.sec), 0);
        check_eq("clr_min", int'(bus.min), 0);
        cyc(3);
        check_eq("clr_tick_early", int'(bus.tick_1hz), 0);
        cyc(1);
        check_eq("clr_tick", int'(bus.tick_1hz), 1);

        // rst in the middle of set mode.
        bus.set_mode = 1'b1;
        pulse_min(1);
        bus.btn_hr = 1'b1;
        rst = 1'b1;
        cyc(1);
        check_eq("rst_set_min", int'(bus.min), 0);
        check_eq("rst_set_hr", int'(bus.count_up_hr), 0);
        rst = 1'b0;
        bus.btn_hr = 1'b0;
        bus.set_mode = 1'b0;

        // Randomised operation against the model.
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            rst_counters = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) bus.set_mode = ~bus.set_mode;
            if ($urandom_range(0, 14) == 0) bus.run_en = ~bus.run_en;
            if ($urandom_range(0, 2) == 0) bus.btn_min = ~bus.btn_min;
            if ($urandom_range(0, 2) == 0) bus.btn_hr = ~bus.btn_hr;
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
